// File: rtl/elastic_stage_rg_pkg.sv
// Shared pipeline types for the elastic stage register: occupancy states and their decode.
package elastic_stage_rg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } st_t;

  function automatic logic [1:0] st_occ(input st_t st);
    logic [1:0] occ;
    occ = 2'd0;
    case (st)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/elastic_stage_rg_areg.sv
// WIDTH-bit register with asynchronous active-high reset and load enable.
module areg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/elastic_stage_rg.sv
// Elastic valid/ready pipeline stage: 2-entry skid buffer, sync flush, occupancy, stall counter.
module elastic_stage_rg
  import elastic_stage_rg_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  st_t                 st_q, st_d;
  logic                in_fire, out_fire;
  logic                main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0]    main_d, skid_q;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d           = st_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Held beats and any beat offered this cycle are discarded; payload regs keep old values.
      st_d = ST_EMPTY;
    end else begin
      case (st_q)
        ST_EMPTY: begin
          if (in_fire) begin
            st_d    = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            st_d    = ST_FULL;
            skid_en = 1'b1;
          end else if (out_fire) begin
            st_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            st_d           = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: st_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (st_q != ST_EMPTY);
    in_ready  = (st_q != ST_FULL);
    occupancy = st_occ(st_q);
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  areg #(
    .WIDTH (WIDTH)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  areg #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: doc/elastic_stage_rg.md
# elastic_stage_rg

Parametrised, handshaked pipeline-stage register that replaces the fixed load/reset MEM/WB-style stage registers with an elastic valid/ready stage. It has a 2-entry skid buffer, a synchronous flush, occupancy reporting and a saturating back-pressure counter. It sits between any two pipeline stages; the payload is the packed concatenation of the stage's fields (ctrl word, data, instruction, PC, ...). Ready is registered on both sides, so no combinational path crosses the stage.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1)
- CNT_WIDTH, 16, width of the stall counter (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; asynchronous, active-high
- flush  in  1  synchronous squash of all held beats
- in_valid  in  1  producer offers in_data
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  WIDTH  incoming payload
- out_valid  out  1  out_data holds a valid beat
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WIDTH  outgoing payload
- occupancy  out  2  beats held: 0, 1 or 2
- stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage:
  - main slot drives out_data.
  - skid slot holds the beat accepted while the consumer stalls.
- States (st_t): ST_EMPTY, ST_ONE, ST_FULL.
- Decoded from state:
  - out_valid = (st != ST_EMPTY)
  - in_ready = (st != ST_FULL)
  - occupancy = 0 / 1 / 2
- Transitions when flush=0:
  - ST_EMPTY: in_fire → ST_ONE, main ← in_data.
  - ST_ONE: in_fire & out_fire → ST_ONE, main ← in_data.
  - ST_ONE: in_fire only → ST_FULL, skid ← in_data.
  - ST_ONE: out_fire only → ST_EMPTY.
  - ST_ONE: neither → hold.
  - ST_FULL: out_fire → ST_ONE, main ← skid; otherwise hold. in_fire is impossible here.
- Flush has the highest priority:
  - next state is ST_EMPTY regardless of handshakes.
  - A beat offered with in_fire in the flush cycle is dropped; the producer treats it as consumed.
  - An out_fire in the flush cycle is a normal consumption.
  - Payload registers are not cleared by flush.
- Stall counter:
  - increments by 1 on every cycle with out_valid & ~out_ready.
  - saturates at 2^CNT_WIDTH−1.
  - not affected by flush; cleared only by rst.
- Order is strictly FIFO; beats are never duplicated or reordered.

## Timing
- Reset values (asynchronous):
  - st = ST_EMPTY, out_valid = 0, in_ready = 1, occupancy = 0
  - out_data = 0, skid = 0, stall_cnt = 0
- Latency: a beat accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. one cycle.
- Throughput: 1 beat per cycle when out_ready is held high.
- in_ready falls the cycle after the stage becomes full. The skid slot absorbs the beat accepted in the cycle the consumer stalled.
- in_ready and out_valid are register outputs. No combinational path exists from out_ready to in_ready, or from in_valid to out_valid.
- When out_valid=1 and out_ready=0, out_data stays stable until out_fire or flush.
- rst asserted mid-transfer: all held beats are lost immediately and outputs take their reset values without waiting for clk.

## Structure
- Shared pipeline package (alongside ctrl_types):
  - typedef enum logic [1:0] st_t {ST_EMPTY, ST_ONE, ST_FULL}
  - function st_occ(st_t) returning the 2-bit occupancy.
- One natural sub-module: areg, a parametrised WIDTH register with async active-high reset and load enable. Instantiate it twice, for the main and skid slots.
- The control FSM and stall counter live in elastic_stage_rg itself.
- A MEM/WB instance sets WIDTH to the packed sum of its fields and drives flush from the hazard unit.

## Test plan
- Reset, then 4 beats 0xA1..0xA4 with out_ready=1 → outputs 0xA1..0xA4 on consecutive cycles, each 1 cycle after acceptance; occupancy stays 1; stall_cnt=0.
- Push 0x11 and 0x22 with out_ready=0 → in_ready=0 after the 2nd beat, occupancy=2, stall_cnt increments each cycle. Raise out_ready → 0x11 then 0x22 delivered; in_ready returns to 1 the cycle after the first pop.
- Stage full (0x33, 0x44), flush=1 with in_valid=1 carrying 0x55 → next cycle occupancy=0, out_valid=0. 0x55 never appears; the next pushed beat 0x66 is the first output.
- CNT_WIDTH=2, hold out_valid=1 with out_ready=0 for 6 cycles → stall_cnt reads 1, 2, 3, 3, 3, 3.
- Assert rst asynchronously between edges while occupancy=2 → out_valid=0, in_ready=1, out_data=0, stall_cnt=0 before the next clk edge.
- Random in_valid/out_ready at 50% each over 10k beats, with a scoreboard → in-order delivery, no loss, and no beat outside flush windows.
